// File: rtl/ripple_count_reader.sv
// Captures a free-running ripple counter into the clk domain: per-bit 2-flop sync,
// stability filter over consecutive samples, and good/error read reporting with delta/wrap.
module ripple_count_reader #(
    parameter int WIDTH      = 3,
    parameter int STABLE_CNT = 2,
    parameter int MAX_TRIES  = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             rd_req,
    output logic             busy,
    output logic             rd_valid,
    output logic             rd_err,
    output logic [WIDTH-1:0] rd_count,
    output logic [WIDTH-1:0] rd_delta,
    output logic             rd_wrap
);

    localparam int CW = $clog2(MAX_TRIES + 1);
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] STABLE_LIM = CW'(STABLE_CNT);
    localparam logic [CW-1:0] TRIES_LIM  = CW'(MAX_TRIES);

    typedef enum logic {IDLE, SAMPLE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sync_meta, sync_val;
    logic [WIDTH-1:0] p, p_nx;
    logic [WIDTH-1:0] last_count, last_nx;
    logic [WIDTH-1:0] count_nx, delta_nx;
    logic [CW-1:0]    match, match_nx, match_inc;
    logic [CW-1:0]    tries, tries_nx, tries_inc;
    logic             busy_nx, valid_nx, err_nx, wrap_nx;

    // Bits are synchronised independently; skew is absorbed by the stability filter.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_meta <= '0;
            sync_val  <= '0;
        end else begin
            sync_meta <= cnt_in;
            sync_val  <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            p          <= '0;
            match      <= '0;
            tries      <= '0;
            last_count <= '0;
            busy       <= 1'b0;
            rd_valid   <= 1'b0;
            rd_err     <= 1'b0;
            rd_wrap    <= 1'b0;
            rd_count   <= '0;
            rd_delta   <= '0;
        end else begin
            state      <= state_nx;
            p          <= p_nx;
            match      <= match_nx;
            tries      <= tries_nx;
            last_count <= last_nx;
            busy       <= busy_nx;
            rd_valid   <= valid_nx;
            rd_err     <= err_nx;
            rd_wrap    <= wrap_nx;
            rd_count   <= count_nx;
            rd_delta   <= delta_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        p_nx      = p;
        match_nx  = match;
        tries_nx  = tries;
        last_nx   = last_count;
        busy_nx   = busy;
        valid_nx  = 1'b0;
        err_nx    = 1'b0;
        wrap_nx   = 1'b0;
        count_nx  = rd_count;
        delta_nx  = rd_delta;
        match_inc = (sync_val == p) ? match + ONE : ONE;
        tries_inc = tries + ONE;

        case (state)
            IDLE: begin
                if (rd_req && enable) begin
                    state_nx = SAMPLE;
                    p_nx     = sync_val;
                    match_nx = ONE;
                    tries_nx = ONE;
                    busy_nx  = 1'b1;
                end
            end
            SAMPLE: begin
                if (!enable) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end else begin
                    tries_nx = tries_inc;
                    match_nx = match_inc;
                    p_nx     = sync_val;
                    // A stable value wins even on the sample that exhausts the try budget.
                    if (match_inc == STABLE_LIM) begin
                        count_nx = sync_val;
                        delta_nx = sync_val - last_count;
                        wrap_nx  = (sync_val < last_count);
                        last_nx  = sync_val;
                        valid_nx = 1'b1;
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                    end else if (tries_inc == TRIES_LIM) begin
                        valid_nx = 1'b1;
                        err_nx   = 1'b1;
                        delta_nx = '0;
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ripple_count_reader.sv
// Directed bench for ripple_count_reader: a queue-based read model is compared every
// cycle, and literal expectations pin latency and results of each scenario.
module tb_ripple_count_reader;

    localparam int WIDTH      = 3;
    localparam int STABLE_CNT = 2;
    localparam int MAX_TRIES  = 8;
    localparam int MODV       = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             enable = 1'b0;
    logic             rd_req = 1'b0;
    logic [WIDTH-1:0] cnt_in = '0;
    logic             busy, rd_valid, rd_err, rd_wrap;
    logic [WIDTH-1:0] rd_count, rd_delta;

    int checks = 0;
    int passes = 0;
    bit run = 1'b0;

    int m_busy = 0, m_valid = 0, m_err = 0, m_wrap = 0;
    int m_count = 0, m_delta = 0, m_last = 0;
    int pipe[$];
    int samp[$];
    bit reading = 1'b0;

    ripple_count_reader #(
        .WIDTH(WIDTH),
        .STABLE_CNT(STABLE_CNT),
        .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk(clk),
        .clr(clr),
        .enable(enable),
        .cnt_in(cnt_in),
        .rd_req(rd_req),
        .busy(busy),
        .rd_valid(rd_valid),
        .rd_err(rd_err),
        .rd_count(rd_count),
        .rd_delta(rd_delta),
        .rd_wrap(rd_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // The synchronised view lags cnt_in by two edges; a read succeeds once the last
    // STABLE_CNT collected samples agree, and fails after MAX_TRIES samples.
    task automatic model_edge();
        int cur;
        bit same;
        cur = pipe.pop_front();
        pipe.push_back(int'(cnt_in));
        m_valid = 0;
        m_err   = 0;
        m_wrap  = 0;
        if (!reading) begin
            if (rd_req && enable) begin
                reading = 1'b1;
                m_busy  = 1;
                samp.delete();
                samp.push_back(cur);
            end
        end else if (!enable) begin
            reading = 1'b0;
            m_busy  = 0;
        end else begin
            samp.push_back(cur);
            same = (samp.size() >= STABLE_CNT);
            if (same)
                for (int i = 0; i < STABLE_CNT; i++)
                    if (samp[samp.size() - 1 - i] != cur) same = 1'b0;
            if (same) begin
                m_valid = 1;
                m_count = cur;
                m_delta = (cur - m_last + MODV) % MODV;
                m_wrap  = int'(cur < m_last);
                m_last  = cur;
                reading = 1'b0;
                m_busy  = 0;
            end else if (samp.size() >= MAX_TRIES) begin
                m_valid = 1;
                m_err   = 1;
                m_delta = 0;
                reading = 1'b0;
                m_busy  = 0;
            end
        end
    endtask

    initial begin
        pipe = '{0, 0};
        forever begin
            @(posedge clk or negedge clr);
            if (!clr) begin
                m_busy = 0; m_valid = 0; m_err = 0; m_wrap = 0;
                m_count = 0; m_delta = 0; m_last = 0;
                pipe = '{0, 0};
                samp.delete();
                reading = 1'b0;
            end else begin
                model_edge();
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("busy", int'(busy), m_busy);
            chk("rd_valid", int'(rd_valid), m_valid);
            chk("rd_err", int'(rd_err), m_err);
            chk("rd_wrap", int'(rd_wrap), m_wrap);
            chk("rd_count", int'(rd_count), m_count);
            chk("rd_delta", int'(rd_delta), m_delta);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int budget, output int n);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        n = 1;
        while (!rd_valid && n < budget) begin
            step();
            n++;
        end
        if (!rd_valid) chk("rd_valid_timeout", 0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

    initial begin
        int n;
        int nvalid;

        // 1: reset, then a stable 5
        #2 clr = 1'b0;
        enable = 1'b1;
        cnt_in = 3'd5;
        #1 run = 1'b1;
        step(); step();
        chk("reset_count", int'(rd_count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(rd_valid), 0);
        clr = 1'b1;
        repeat (4) step();
        do_read(20, n);
        chk("t1_latency", n, STABLE_CNT);
        chk("t1_count", int'(rd_count), 5);
        chk("t1_delta", int'(rd_delta), 5);
        chk("t1_wrap", int'(rd_wrap), 0);
        chk("t1_err", int'(rd_err), 0);
        chk("t1_model_count", m_count, 5);

        // 2: stable 2 -> wrap
        step();
        cnt_in = 3'd2;
        repeat (3) step();
        do_read(20, n);
        chk("t2_latency", n, STABLE_CNT);
        chk("t2_count", int'(rd_count), 2);
        chk("t2_delta", int'(rd_delta), 5);
        chk("t2_wrap", int'(rd_wrap), 1);
        chk("t2_model_wrap", m_wrap, 1);
        step();
        chk("t2_wrap_cleared", int'(rd_wrap), 0);
        chk("t2_count_held", int'(rd_count), 2);

        // 3: toggling 3/4 never settles
        cnt_in = 3'd3;
        for (int i = 0; i < 4; i++) begin
            cnt_in = cnt_in ^ 3'd7;
            step();
        end
        cnt_in = cnt_in ^ 3'd7;
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        n = 1;
        while (!rd_valid && n < 30) begin
            cnt_in = cnt_in ^ 3'd7;
            step();
            n++;
        end
        if (!rd_valid) chk("t3_timeout", 0, 1);
        chk("t3_latency", n, MAX_TRIES);
        chk("t3_err", int'(rd_err), 1);
        chk("t3_count", int'(rd_count), 2);
        chk("t3_delta", int'(rd_delta), 0);
        chk("t3_model_err", m_err, 1);

        // 4: 3, one-cycle glitch to 7, settle at 4
        cnt_in = 3'd3;
        repeat (3) step();
        cnt_in = 3'd7;
        step();
        cnt_in = 3'd4;
        do_read(20, n);
        chk("t4_latency", n, 4);
        chk("t4_count", int'(rd_count), 4);
        chk("t4_delta", int'(rd_delta), 2);
        chk("t4_err", int'(rd_err), 0);

        // 5a: enable dropped right after acceptance aborts without rd_valid
        step();
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        chk("t5_busy_on", int'(busy), 1);
        enable = 1'b0;
        step();
        chk("t5_busy_off", int'(busy), 0);
        chk("t5_no_valid", int'(rd_valid), 0);
        enable = 1'b1;
        step();
        chk("t5_idle", int'(busy), 0);

        // 5b: request held while busy is not queued
        rd_req = 1'b1;
        step();
        chk("t5_busy_again", int'(busy), 1);
        step();
        rd_req = 1'b0;
        chk("t5_read_done", int'(rd_valid), 1);
        chk("t5_read_delta", int'(rd_delta), 0);
        nvalid = 0;
        repeat (5) begin
            step();
            if (rd_valid) nvalid++;
        end
        chk("t5_no_second_read", nvalid, 0);
        chk("t5_busy_end", int'(busy), 0);

        // 6: reset mid-read, then baseline restarts at 0
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        chk("t6_busy", int'(busy), 1);
        #2 clr = 1'b0;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_count", int'(rd_count), 0);
        chk("t6_rst_delta", int'(rd_delta), 0);
        chk("t6_rst_valid", int'(rd_valid), 0);
        cnt_in = 3'd6;
        step();
        clr = 1'b1;
        repeat (3) step();
        do_read(20, n);
        chk("t6_latency", n, STABLE_CNT);
        chk("t6_count", int'(rd_count), 6);
        chk("t6_delta", int'(rd_delta), 6);
        chk("t6_wrap", int'(rd_wrap), 0);
        chk("t6_model_delta", m_delta, 6);

        step(); step();
        run = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
